dilate_window_scheduler: RTL and testbench
==========================================

// Module: dilate_window_scheduler
// PURPOSE
// - Raster-scan sequencer for one DilateNode: takes a binary image one pixel per handshake and builds the Width x Height neighbourhood from Height-1 line buffers and a window register.
// - Drives the node's D/element inputs, captures its Q, and emits the dilated image in raster order.
// - Holds the structuring-element configuration register. Sits between the pixel source and the morphology output stream.
// PARAMETERS
// Width   3   window columns; must be odd
// Height  3   window rows; must be odd
// ImgW    16  image width in pixels, >= Width
// ImgH    16  image height in pixels, >= Height
// PORTS
// clk           in   1              single clock, rising edge
// rst           in   1              asynchronous, active-high reset
// cfg_we        in   1              load cfg_element (honoured in IDLE only)
// cfg_element   in   Width*Height   structuring element, same bit layout as D
// start         in   1              begin one frame (honoured in IDLE only)
// busy          out  1              state != IDLE
// done          out  1              1-cycle pulse when the last output pixel handshakes
// in_valid      in   1              input pixel valid
// in_ready      out  1              input pixel accepted when in_valid & in_ready
// in_pixel      in   1              input pixel, raster order (x fastest)
// node_D        out  Width*Height   masked window to DilateNode D; bit l*Width+c = row l (0 = top), col c (0 = left)
// node_element  out  Width*Height   element register, passed unmodified
// node_Q        in   1              DilateNode result (combinational on node_D/node_element)
// out_valid     out  1              output pixel valid
// out_ready     in   1              downstream accepts when out_valid & out_ready
// out_pixel     out  1              dilated pixel, raster order
// out_last      out  1              high with out_valid on the final pixel (ImgW-1, ImgH-1)
// BEHAVIOUR
// - Reset: state=IDLE; busy, done, in_ready, out_valid, out_pixel, out_last = 0; element reg = all 1s; line buffers, window and counters = 0.
// - States and transitions:
//   - IDLE->FILL on start.
//   - FILL->RUN after L = (Height/2)*ImgW + Width/2 input pixels are accepted.
//   - RUN->FLUSH after ImgW*ImgH input pixels are accepted.
//   - FLUSH->IDLE when the last output handshakes (done pulses in that same cycle).
// - Step: one shift of the pipeline.
//   - Shift in one pixel: in_pixel in FILL/RUN, constant 0 in FLUSH.
//   - Each line buffer passes its oldest bit to the next row.
//   - The window shifts left by one column.
//   - Rows feed from line buffers; bottom row from the new pixel.
// - Step enable: step_ok = !win_valid | out_load.
//   - FILL/RUN: in_ready = step_ok; step on in_valid & in_ready.
//   - FLUSH: in_ready = 0; step on every step_ok cycle, exactly L steps.
// - Window valid: win_valid is set by any step in RUN or FLUSH, else cleared when out_load.
// - Output load: out_load = win_valid & (!out_valid | out_ready); loads out_pixel <= node_Q.
//   - out_valid set on out_load, cleared on handshake without out_load.
//   - Latency: 2 clk from the completing input handshake to out_valid, with no backpressure.
//   - Full throughput: 1 pixel/clk while out_ready=1.
// - Center counters (cx, cy) advance on each out_load; cx wraps at ImgW-1, then cy increments.
// - Border masking, applied in node_D: zero every window bit whose image coordinate lies outside the frame.
//   - Columns: cx + c - Width/2 outside [0, ImgW-1]. No wrap-around into the adjacent row.
//   - Rows: cy + l - Height/2 outside [0, ImgH-1].
// - Exactly ImgW*ImgH outputs per frame; out_last on cx=ImgW-1, cy=ImgH-1.
// - Ignored inputs:
//   - cfg_we and start outside IDLE.
//   - in_valid in IDLE and FLUSH (in_ready=0).
//   - Simultaneous cfg_we & start in IDLE: both take effect; the new element applies to the frame.
// - Backpressure: out_ready=0 holds out_pixel, out_last and the whole pipeline stable (no steps).
// - Reset mid-frame: asynchronous return to reset values; the partial frame is discarded and the element reg returns to all 1s.
// TESTING
// - Reset: assert rst mid-RUN -> next cycle busy=0, out_valid=0, in_ready=0, element=9'h1FF; a new start then processes a full frame cleanly.
// - Cross element 9'b010_111_010, 16x16 frame, single 1 at (5,5) -> exactly (4..6,5) and (5,4),(5,6) are 1; 256 outputs, out_last on #256, done one pulse.
// - Border/no-wrap: single 1 at (15,0), all-ones element -> 1s at (14..15, 0..1) only; (0,1) must be 0. Single 1 at (0,15) -> 1s at (0..1, 14..15) only.
// - Throughput/latency: in_valid=1 and out_ready=1 continuously -> first out_valid 2 clk after input #18 (L=17); then 1 pixel/clk; frame done after 256+ few cycles.
// - Backpressure: random out_ready (50%) and in_valid gaps -> output bit-identical to golden model; no pixel lost or duplicated; outputs stable while stalled.
// - Config guard: cfg_we with a new element during RUN -> ignored (node_element unchanged); cfg_we in IDLE -> used by the next frame.

Source files
------------

// File: rtl/dilate_window_scheduler.sv
// Raster-scan sequencer for one DilateNode: line buffers + window register build the
// Width x Height neighbourhood, border-masked into node_D; node_Q is streamed out in raster order.
module dilate_window_scheduler #(
  parameter int Width  = 3,
  parameter int Height = 3,
  parameter int ImgW   = 16,
  parameter int ImgH   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [Width*Height-1:0]   cfg_element,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_pixel,
  output logic [Width*Height-1:0]   node_D,
  output logic [Width*Height-1:0]   node_element,
  input  logic                      node_Q,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_pixel,
  output logic                      out_last
);

  localparam int N    = Width * Height;
  localparam int L    = (Height / 2) * ImgW + Width / 2;
  localparam int NPIX = ImgW * ImgH;
  localparam int LEN  = (Height - 1) * ImgW + Width;
  localparam int CXW  = (ImgW > 1) ? $clog2(ImgW) : 1;
  localparam int CYW  = (ImgH > 1) ? $clog2(ImgH) : 1;
  localparam int ICW  = $clog2(NPIX + 1);
  localparam int FCW  = $clog2(L + 1);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid never depends on ready, and out_pixel/out_last hold while out_valid & !out_ready.

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t          state, state_next;
  logic [LEN-1:0]  chain;
  logic [N-1:0]    element;
  logic            win_valid;
  logic [ICW-1:0]  in_cnt;
  logic [FCW-1:0]  flush_cnt;
  logic [CXW-1:0]  cx;
  logic [CYW-1:0]  cy;
  logic            step_ok, out_load, out_hs, step, step_win, new_bit, last_pos;
  logic [N-1:0]    window, mask;
  logic [Width-1:0]  col_ok;
  logic [Height-1:0] row_ok;

  assign out_load = win_valid & (~out_valid | out_ready);
  assign step_ok  = ~win_valid | out_load;
  assign out_hs   = out_valid & out_ready;
  assign busy     = (state != IDLE);
  assign last_pos = (cx == CXW'(ImgW - 1)) && (cy == CYW'(ImgH - 1));
  assign step_win = step & ((state == RUN) | (state == FLUSH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    step       = 1'b0;
    new_bit    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = FILL;
      end
      FILL: begin
        in_ready = step_ok;
        step     = in_valid & step_ok;
        new_bit  = in_pixel;
        if (step && in_cnt == ICW'(L - 1)) state_next = RUN;
      end
      RUN: begin
        in_ready = step_ok;
        step     = in_valid & step_ok;
        new_bit  = in_pixel;
        if (step && in_cnt == ICW'(NPIX - 1)) state_next = FLUSH;
      end
      FLUSH: begin
        // Zeros are pushed in to drain the last L centre positions.
        step = step_ok && (flush_cnt != FCW'(L));
        if (out_hs && out_last) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain     <= '0;
      element   <= '1;
      win_valid <= 1'b0;
      in_cnt    <= '0;
      flush_cnt <= '0;
      cx        <= '0;
      cy        <= '0;
      out_valid <= 1'b0;
      out_pixel <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (cfg_we) element <= cfg_element;
        if (start) begin
          chain     <= '0;
          win_valid <= 1'b0;
          in_cnt    <= '0;
          flush_cnt <= '0;
          cx        <= '0;
          cy        <= '0;
        end
      end
      // chain[0] is the newest pixel; line buffers and window are one contiguous shift chain.
      if (step) chain <= {chain[LEN-2:0], new_bit};
      if (step_win)      win_valid <= 1'b1;
      else if (out_load) win_valid <= 1'b0;
      if (step && state != FLUSH) in_cnt    <= in_cnt + 1'b1;
      if (step && state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
      if (out_load) begin
        out_pixel <= node_Q;
        out_last  <= last_pos;
        out_valid <= 1'b1;
        if (cx == CXW'(ImgW - 1)) begin
          cx <= '0;
          cy <= (cy == CYW'(ImgH - 1)) ? '0 : cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Window tap (l, c) is the pixel shifted in (Height-1-l) rows and (Width-1-c) columns ago.
  for (genvar l = 0; l < Height; l++) begin : g_row
    assign row_ok[l] = (int'(cy) + l - Height / 2 >= 0) && (int'(cy) + l - Height / 2 < ImgH);
    for (genvar c = 0; c < Width; c++) begin : g_col
      assign window[l*Width+c] = chain[(Height-1-l)*ImgW + (Width-1-c)];
      assign mask[l*Width+c]   = row_ok[l] & col_ok[c];
    end
  end

  for (genvar c = 0; c < Width; c++) begin : g_colok
    assign col_ok[c] = (int'(cx) + c - Width / 2 >= 0) && (int'(cx) + c - Width / 2 < ImgW);
  end

  assign node_D       = window & mask;
  assign node_element = element;

endmodule

// File: tb/tb_dilate_window_scheduler.sv
// Self-checking bench for dilate_window_scheduler: random frames against a direct
// neighbourhood-dilation model, plus reset, latency, border, backpressure and config cases.
module tb_dilate_window_scheduler;

  localparam int W    = 3;
  localparam int H    = 3;
  localparam int IW   = 16;
  localparam int IH   = 16;
  localparam int N    = W * H;
  localparam int NPIX = IW * IH;
  localparam int L    = (H / 2) * IW + W / 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_we;
  logic [N-1:0] cfg_element;
  logic         start;
  logic         busy, done;
  logic         in_valid, in_ready, in_pixel;
  logic [N-1:0] node_D, node_element;
  logic         node_Q;
  logic         out_valid, out_ready, out_pixel, out_last;

  dilate_window_scheduler #(.Width(W), .Height(H), .ImgW(IW), .ImgH(IH)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_element(cfg_element), .start(start),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .node_D(node_D), .node_element(node_element), .node_Q(node_Q),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel), .out_last(out_last)
  );

  // Stand-in DilateNode: any element-selected neighbour set.
  assign node_Q = |(node_D & node_element);

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  string cur_test;

  logic       img [NPIX];
  logic [1:0] exp_q[$];
  int ones_seen, done_cnt, hs_mark_cyc, first_out_cyc, last_out_cyc, in_hs;

  // Reference: output(x,y) = OR of in-frame image pixels selected by the element around (x,y).
  function automatic void build_exp(input logic [N-1:0] elem);
    exp_q.delete();
    for (int y = 0; y < IH; y++) begin
      for (int x = 0; x < IW; x++) begin
        logic v;
        v = 1'b0;
        for (int l = 0; l < H; l++) begin
          for (int c = 0; c < W; c++) begin
            int yy, xx;
            yy = y + l - H / 2;
            xx = x + c - W / 2;
            if (yy >= 0 && yy < IH && xx >= 0 && xx < IW && elem[l*W+c] && img[yy*IW+xx])
              v = 1'b1;
          end
        end
        exp_q.push_back({(x == IW - 1 && y == IH - 1), v});
      end
    end
  endfunction

  task automatic clear_img();
    for (int i = 0; i < NPIX; i++) img[i] = 1'b0;
  endtask

  task automatic fill_random(input int pct);
    for (int i = 0; i < NPIX; i++) img[i] = ($urandom_range(0, 99) < pct);
  endtask

  task automatic drive_inputs(input int gap_pct, input int deadline);
    in_hs = 0;
    for (int i = 0; i < NPIX && cyc < deadline; i++) begin
      bit taken;
      taken = 1'b0;
      if ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_pixel = img[i];
      while (!taken && cyc < deadline) begin
        @(negedge clk);
        if (in_ready) begin
          taken = 1'b1;
          in_hs++;
          if (in_hs == L + 1) hs_mark_cyc = cyc;
        end
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic collect_outputs(input int rdy_pct, input int deadline, output int n_out);
    logic       stall = 1'b0;
    logic       sp = 1'b0, sl = 1'b0;
    logic [1:0] e;
    n_out = 0; ones_seen = 0; done_cnt = 0; first_out_cyc = -1; last_out_cyc = -1;
    while (n_out < NPIX && cyc < deadline) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      if (done) done_cnt++;
      if (stall) begin
        total++;
        if (out_valid !== 1'b1 || out_pixel !== sp || out_last !== sl) begin
          bad++;
          $display("FAIL %s stall_hold: got v=%b p=%b l=%b need v=1 p=%b l=%b",
                   cur_test, out_valid, out_pixel, out_last, sp, sl);
        end
      end
      stall = out_valid && !out_ready;
      sp = out_pixel;
      sl = out_last;
      if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        total++;
        if ({out_last, out_pixel} !== e) begin
          bad++;
          $display("FAIL %s pixel %0d (x=%0d y=%0d): got last,pix=%b need %b",
                   cur_test, n_out, n_out % IW, n_out / IW, {out_last, out_pixel}, e);
        end
        n_out++;
        if (out_pixel) ones_seen++;
        last_out_cyc = cyc;
      end
    end
  endtask

  task automatic poke_cfg(input logic [N-1:0] elem);
    repeat (100) @(posedge clk);
    #1;
    if (busy) begin
      cfg_we = 1'b1; start = 1'b1; cfg_element = ~elem;
      @(posedge clk); #1;
      cfg_we = 1'b0; start = 1'b0; cfg_element = elem;
      @(negedge clk);
      total++;
      if (node_element !== elem) begin
        bad++;
        $display("FAIL %s cfg_guard: node_element=%h need %h", cur_test, node_element, elem);
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; start = 1'b0; cfg_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_frame(input logic [N-1:0] elem, input bit with_start, input int gap,
                           input int rdy, input bit poke);
    int deadline, n_out;
    build_exp(elem);
    @(posedge clk); #1;
    cfg_we = 1'b1;
    cfg_element = elem;
    if (!with_start) begin
      @(posedge clk); #1;
      cfg_we = 1'b0;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_we = 1'b0;
    deadline = cyc + 8000;
    fork
      drive_inputs(gap, deadline);
      collect_outputs(rdy, deadline, n_out);
      begin if (poke) poke_cfg(elem); end
    join
    total++;
    if (n_out != NPIX) begin
      bad++;
      $display("FAIL %s frame_count: got %0d outputs need %0d (timeout)", cur_test, n_out, NPIX);
      pulse_reset();
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL %s done_pulses: got %0d need 1", cur_test, done_cnt);
    end
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_after_frame: got %b need 0", cur_test, busy);
    end
  endtask

  task automatic test_reset();
    cur_test = "reset";
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
        out_pixel !== 1'b0 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL reset outputs: busy=%b done=%b in_ready=%b ov=%b op=%b ol=%b need all 0",
               busy, done, in_ready, out_valid, out_pixel, out_last);
    end
    total++;
    if (node_element !== 9'h1FF) begin
      bad++;
      $display("FAIL reset element: got %h need 1ff", node_element);
    end
  endtask

  task automatic test_cross();
    cur_test = "cross";
    clear_img();
    img[5*IW+5] = 1'b1;
    run_frame(9'b010_111_010, 1'b0, 0, 100, 1'b0);
    total++;
    if (ones_seen != 5) begin
      bad++;
      $display("FAIL cross ones: got %0d need 5", ones_seen);
    end
  endtask

  task automatic test_border();
    cur_test = "border_15_0";
    clear_img();
    img[15] = 1'b1;
    run_frame(9'h1FF, 1'b0, 0, 100, 1'b0);
    total++;
    if (ones_seen != 4) begin
      bad++;
      $display("FAIL border_15_0 ones: got %0d need 4", ones_seen);
    end
    cur_test = "border_0_15";
    clear_img();
    img[15*IW] = 1'b1;
    run_frame(9'h1FF, 1'b0, 20, 70, 1'b0);
    total++;
    if (ones_seen != 4) begin
      bad++;
      $display("FAIL border_0_15 ones: got %0d need 4", ones_seen);
    end
  endtask

  task automatic test_latency();
    cur_test = "latency";
    fill_random(40);
    run_frame(N'($urandom_range(0, 511)), 1'b0, 0, 100, 1'b0);
    total++;
    if (first_out_cyc - hs_mark_cyc != 2) begin
      bad++;
      $display("FAIL latency first_out: got %0d clk need 2", first_out_cyc - hs_mark_cyc);
    end
    total++;
    if (last_out_cyc - first_out_cyc != NPIX - 1) begin
      bad++;
      $display("FAIL latency throughput: got %0d clk need %0d", last_out_cyc - first_out_cyc, NPIX - 1);
    end
  endtask

  task automatic test_backpressure();
    for (int f = 0; f < 3; f++) begin
      cur_test = $sformatf("backpressure%0d", f);
      fill_random(35);
      run_frame(N'($urandom_range(0, 511)), 1'b0, 30, 50, 1'b0);
    end
  endtask

  task automatic test_cfg_guard();
    cur_test = "cfg_guard";
    fill_random(30);
    run_frame(9'b010_111_010, 1'b0, 30, 50, 1'b1);
  endtask

  task automatic test_simul_cfg_start();
    cur_test = "cfg_with_start";
    fill_random(25);
    run_frame(9'b100_010_001, 1'b1, 10, 80, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    cur_test = "reset_mid";
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_element = 9'h0AA;
    @(posedge clk); #1;
    cfg_we = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      in_pixel = $urandom_range(0, 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || node_element !== 9'h0AA) begin
      bad++;
      $display("FAIL reset_mid pre: busy=%b elem=%h need 1 0aa", busy, node_element);
    end
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 ||
        node_element !== 9'h1FF) begin
      bad++;
      $display("FAIL reset_mid post: busy=%b ov=%b ir=%b done=%b elem=%h need 0 0 0 0 1ff",
               busy, out_valid, in_ready, done, node_element);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cur_test = "after_reset";
    fill_random(50);
    run_frame(9'h1FF, 1'b0, 15, 60, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_element = '0; start = 1'b0;
    in_valid = 1'b0; in_pixel = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_cross();
    test_border();
    test_latency();
    test_backpressure();
    test_cfg_guard();
    test_simul_cfg_start();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
